// File: rtl/traffic_light_sequencer.sv
// Two-road intersection sequencer: NS/EW green-yellow-all-red cycle, night-mode
// flashing yellow, one-second prescaler and a two-digit BCD countdown display.
module traffic_light_sequencer #(
   parameter int unsigned TICK_DIV = 50_000_000,
   parameter int unsigned GREEN_S  = 25,
   parameter int unsigned YELLOW_S = 3,
   parameter int unsigned ALLRED_S = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       night_mode,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       blank,
   output logic [2:0] phase
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      NS_G  = 3'd0,
      NS_Y  = 3'd1,
      RED_A = 3'd2,
      EW_G  = 3'd3,
      EW_Y  = 3'd4,
      RED_B = 3'd5,
      FLASH = 3'd6
   } state_t;

   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] YELLOW = 3'b010;
   localparam logic [2:0] GREEN  = 3'b001;

   function automatic logic [7:0] to_bcd(input int unsigned v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   // FLASH shows no countdown, so its load value is 00.
   function automatic logic [7:0] duration_bcd(input state_t s);
      case (s)
         NS_G, EW_G:   return to_bcd(GREEN_S);
         NS_Y, EW_Y:   return to_bcd(YELLOW_S);
         RED_A, RED_B: return to_bcd(ALLRED_S);
         default:      return 8'h00;
      endcase
   endfunction

   state_t        state_q, state_n;
   logic [3:0]    tens_q, ones_q, tens_n, ones_n;
   logic [PW-1:0] presc_q;
   logic          f_q, f_n;
   logic          tick;

   assign tick = enable && (presc_q == PRESC_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
      end else if (enable) begin
         presc_q <= tick ? '0 : presc_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RED_B;
         {tens_q, ones_q} <= to_bcd(ALLRED_S);
         f_q <= 1'b0;
      end else begin
         state_q <= state_n;
         tens_q  <= tens_n;
         ones_q  <= ones_n;
         f_q     <= f_n;
      end
   end

   always_comb begin
      state_n = state_q;
      tens_n  = tens_q;
      ones_n  = ones_q;
      f_n     = f_q;
      if (tick) begin
         if (state_q == FLASH) begin
            if (!night_mode) begin
               state_n = RED_B;
               f_n     = 1'b0;
               {tens_n, ones_n} = duration_bcd(RED_B);
            end else begin
               f_n = ~f_q;
            end
         end else if (tens_q == 4'd0 && ones_q == 4'd1) begin
            // Night mode is only honoured at the end of an all-red clearance.
            case (state_q)
               NS_G:    state_n = NS_Y;
               NS_Y:    state_n = RED_A;
               RED_A:   state_n = night_mode ? FLASH : EW_G;
               EW_G:    state_n = EW_Y;
               EW_Y:    state_n = RED_B;
               RED_B:   state_n = night_mode ? FLASH : NS_G;
               default: state_n = RED_B;
            endcase
            f_n = (state_n == FLASH);
            {tens_n, ones_n} = duration_bcd(state_n);
         end else if (ones_q == 4'd0) begin
            ones_n = 4'd9;
            tens_n = tens_q - 4'd1;
         end else begin
            ones_n = ones_q - 4'd1;
         end
      end
   end

   always_comb begin
      ns_light = RED;
      ew_light = RED;
      case (state_q)
         NS_G:    ns_light = GREEN;
         NS_Y:    ns_light = YELLOW;
         EW_G:    ew_light = GREEN;
         EW_Y:    ew_light = YELLOW;
         FLASH: begin
            ns_light = {1'b0, f_q, 1'b0};
            ew_light = {1'b0, f_q, 1'b0};
         end
         default: ;
      endcase
   end

   assign tens  = tens_q;
   assign ones  = ones_q;
   assign blank = (state_q == FLASH);
   assign phase = state_q;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Directed bench for traffic_light_sequencer: seconds-level reference model
// compared every cycle, plus hand-computed literal checkpoints.
module tb_traffic_light_sequencer;

   localparam int TICK_DIV = 4;
   localparam int GREEN_S  = 12;
   localparam int YELLOW_S = 2;
   localparam int ALLRED_S = 1;

   logic       clk, rst_n, enable, night_mode;
   logic [2:0] ns_light, ew_light, phase;
   logic [3:0] tens, ones;
   logic       blank;

   int checks = 0;
   int errors = 0;
   int k = 0;

   traffic_light_sequencer #(
      .TICK_DIV(TICK_DIV), .GREEN_S(GREEN_S), .YELLOW_S(YELLOW_S), .ALLRED_S(ALLRED_S)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .night_mode(night_mode),
      .ns_light(ns_light), .ew_light(ew_light), .tens(tens), .ones(ones),
      .blank(blank), .phase(phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: phase number, whole seconds left, cycles into current second.
   int m_phase, m_rem, m_sub, n_phase, n_rem, n_sub;
   bit m_f, n_f;

   function automatic int phase_seconds(input int p);
      case (p)
         0, 3:    return GREEN_S;
         1, 4:    return YELLOW_S;
         2, 5:    return ALLRED_S;
         default: return 0;
      endcase
   endfunction

   always_comb begin
      n_phase = m_phase;
      n_rem   = m_rem;
      n_sub   = m_sub;
      n_f     = m_f;
      if (enable) begin
         n_sub = m_sub + 1;
         if (n_sub == TICK_DIV) begin
            n_sub = 0;
            if (m_phase == 6) begin
               if (night_mode) n_f = !m_f;
               else begin n_phase = 5; n_rem = ALLRED_S; n_f = 0; end
            end else if (m_rem > 1) begin
               n_rem = m_rem - 1;
            end else if ((m_phase == 2 || m_phase == 5) && night_mode) begin
               n_phase = 6; n_rem = 0; n_f = 1;
            end else begin
               n_phase = (m_phase + 1) % 6;
               n_rem   = phase_seconds(n_phase);
            end
         end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= 5; m_rem <= ALLRED_S; m_sub <= 0; m_f <= 0;
      end else begin
         m_phase <= n_phase; m_rem <= n_rem; m_sub <= n_sub; m_f <= n_f;
      end
   end

   function automatic logic [17:0] model_vec();
      logic [2:0] ns, ew;
      ns = 3'b100; ew = 3'b100;
      case (m_phase)
         0: ns = 3'b001;
         1: ns = 3'b010;
         3: ew = 3'b001;
         4: ew = 3'b010;
         6: begin ns = {1'b0, m_f, 1'b0}; ew = {1'b0, m_f, 1'b0}; end
         default: ;
      endcase
      return {3'(m_phase), ns, ew, 4'(m_rem / 10), 4'(m_rem % 10), m_phase == 6};
   endfunction

   function automatic logic [17:0] dut_vec();
      return {phase, ns_light, ew_light, tens, ones, blank};
   endfunction

   task automatic compare(input string nm, input logic [17:0] got, input logic [17:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s k=%0d got=%b exp=%b (phase,ns,ew,tens,ones,blank)", nm, k, got, exp);
      end
   endtask

   // Per-cycle model comparison and safety invariant.
   always @(negedge clk) begin
      compare("model", dut_vec(), model_vec());
      checks++;
      if ((ns_light[0] || ew_light[0]) && !ns_light[2] && !ew_light[2]) begin
         errors++;
         $display("FAIL safety k=%0d ns=%b ew=%b", k, ns_light, ew_light);
      end
   end

   task automatic lit(input string nm, input int ph, input int t, input int o,
                      input logic [2:0] ns, input logic [2:0] ew, input logic bl);
      compare(nm, dut_vec(), {3'(ph), ns, ew, 4'(t), 4'(o), bl});
   endtask

   task automatic goto(input int target);
      repeat (target - k) @(posedge clk);
      @(negedge clk);
      k = target;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; enable = 1'b1; night_mode = 1'b0;
      repeat (3) @(negedge clk);
      lit("reset", 5, 0, 1, 3'b100, 3'b100, 0);
      rst_n = 1'b1;
      k = 0;
      lit("k0_red_b", 5, 0, 1, 3'b100, 3'b100, 0);
      goto(3);   lit("k3_red_b", 5, 0, 1, 3'b100, 3'b100, 0);
      goto(4);   lit("first_ns_g", 0, 1, 2, 3'b001, 3'b100, 0);
      goto(12);  lit("bcd_10", 0, 1, 0, 3'b001, 3'b100, 0);
      goto(16);  lit("bcd_09", 0, 0, 9, 3'b001, 3'b100, 0);
      goto(52);  lit("ns_y", 1, 0, 2, 3'b010, 3'b100, 0);
      goto(60);  lit("red_a", 2, 0, 1, 3'b100, 3'b100, 0);
      goto(64);  lit("ew_g", 3, 1, 2, 3'b100, 3'b001, 0);
      goto(112); lit("ew_y", 4, 0, 2, 3'b100, 3'b010, 0);
      goto(120); lit("red_b", 5, 0, 1, 3'b100, 3'b100, 0);
      goto(124); lit("ns_g_cycle2", 0, 1, 2, 3'b001, 3'b100, 0);

      // Freeze for 7 edges in the middle of NS_G.
      goto(130);
      enable = 1'b0;
      goto(134); lit("freeze_hold", 0, 1, 1, 3'b001, 3'b100, 0);
      goto(137);
      enable = 1'b1;

      // Short night pulse inside NS_G must be ignored.
      goto(140);
      night_mode = 1'b1;
      goto(142);
      night_mode = 1'b0;

      goto(178); lit("freeze_late_01", 0, 0, 1, 3'b001, 3'b100, 0);
      goto(179); lit("freeze_ns_y", 1, 0, 2, 3'b010, 3'b100, 0);
      goto(187); lit("pulse_red_a", 2, 0, 1, 3'b100, 3'b100, 0);
      goto(191); lit("pulse_ew_g", 3, 1, 2, 3'b100, 3'b001, 0);

      // Night mode requested during EW_G.
      goto(200);
      night_mode = 1'b1;
      goto(239); lit("night_ew_y", 4, 0, 2, 3'b100, 3'b010, 0);
      goto(247); lit("night_red_b", 5, 0, 1, 3'b100, 3'b100, 0);
      goto(251); lit("flash_on", 6, 0, 0, 3'b010, 3'b010, 1);
      goto(254); lit("flash_hold", 6, 0, 0, 3'b010, 3'b010, 1);
      goto(255); lit("flash_off", 6, 0, 0, 3'b000, 3'b000, 1);
      goto(259); lit("flash_on2", 6, 0, 0, 3'b010, 3'b010, 1);
      goto(260);
      night_mode = 1'b0;
      goto(262); lit("flash_wait", 6, 0, 0, 3'b010, 3'b010, 1);
      goto(263); lit("exit_red_b", 5, 0, 1, 3'b100, 3'b100, 0);
      goto(267); lit("exit_ns_g", 0, 1, 2, 3'b001, 3'b100, 0);

      // Asynchronous reset between edges during EW_Y.
      goto(375); lit("pre_rst_ew_y", 4, 0, 2, 3'b100, 3'b010, 0);
      goto(378);
      #2 rst_n = 1'b0;
      #1 lit("async_reset", 5, 0, 1, 3'b100, 3'b100, 0);
      #1 rst_n = 1'b1;
      k = 0;
      goto(3);  lit("post_rst_red_b", 5, 0, 1, 3'b100, 3'b100, 0);
      goto(4);  lit("post_rst_ns_g", 0, 1, 2, 3'b001, 3'b100, 0);
      goto(20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/traffic_light_sequencer.md
# traffic_light_sequencer

Two-road intersection controller sequencing the North-South and East-West signal heads through green, yellow and all-red phases. It has a night-mode flashing-yellow override. A prescaler derives a one-second tick. A two-digit BCD countdown of seconds remaining in the current phase feeds the design's BCD-to-7-segment decoders, with a blank output that drives the decoders' blanking reset.

## Interface
- TICK_DIV, 50_000_000: clock cycles per one-second tick, ≥2.
- GREEN_S, 25: green duration in seconds, 1..99.
- YELLOW_S, 3: yellow duration in seconds, 1..99.
- ALLRED_S, 2: all-red clearance in seconds, 1..99.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset; asynchronous assert, active-low.
- enable  in  1  1 = run; 0 = freeze prescaler, phase and countdown.
- night_mode  in  1  flashing-yellow request, level-sensitive.
- ns_light  out  3  {red, yellow, green} for the NS head, one-hot or all-zero.
- ew_light  out  3  {red, yellow, green} for the EW head.
- tens  out  4  BCD tens digit of seconds remaining.
- ones  out  4  BCD ones digit of seconds remaining.
- blank  out  1  1 = display off; connects to the decoder blanking input.
- phase  out  3  current state code, for debug and status.

## Operation
- States and codes: NS_G=0, NS_Y=1, RED_A=2, EW_G=3, EW_Y=4, RED_B=5, FLASH=6.
- Normal cycle: NS_G → NS_Y → RED_A → EW_G → EW_Y → RED_B → NS_G.
- Phase durations:
  - NS_G/EW_G: GREEN_S
  - NS_Y/EW_Y: YELLOW_S
  - RED_A/RED_B: ALLRED_S
- Lights by state:
  - NS_G: ns=001, ew=100
  - NS_Y: ns=010, ew=100
  - RED_A/RED_B: ns=100, ew=100
  - EW_G: ns=100, ew=001
  - EW_Y: ns=100, ew=010
  - FLASH: ns=ew={0,f,0}, where f is the flash bit
- Prescaler: counts 0..TICK_DIV-1 on each cycle with enable=1. A tick is consumed on the edge where it equals TICK_DIV-1; it wraps to 0 on that edge.
- Countdown: BCD pair {tens, ones}, loaded with the phase duration on phase entry. On each tick:
  - if the count is 01: transition to the next state and load the next duration;
  - otherwise: decrement in BCD (ones 0 → 9 with tens borrow).
  - The display therefore shows N..1 and never 00 in normal states.
- Night mode is sampled only at the RED_A or RED_B expiry tick. If night_mode=1 there, go to FLASH instead of the next green. Entry into FLASH sets f=1.
- In FLASH:
  - f toggles on every tick;
  - blank=1; the countdown holds 00.
  - At a tick with night_mode=0: go to RED_B, load ALLRED_S, set f=0, then continue the normal cycle from NS_G.
- blank=0 in all states except FLASH.
- enable=0 holds every register, including the prescaler, countdown, state and f.
- Invariant: no state drives green or yellow on both heads at once. A head never goes green without passing through RED_A or RED_B.

## Timing
- Reset (rst_n=0, async) values:
  - state=RED_B, count=ALLRED_S in BCD, prescaler=0, f=0
  - ns_light=ew_light=100, blank=0, phase=5
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- With enable held at 1, the first tick after reset release is consumed on the TICK_DIV-th rising edge.
- A phase of D seconds lasts exactly D*TICK_DIV enabled cycles.
- State, lights, phase and the new count all change on the same edge as the expiring tick.
- A night_mode pulse that does not overlap a RED_A or RED_B expiry tick is ignored.
- A deasserted enable coinciding with a would-be tick edge suppresses that tick; it is consumed later, when enable returns.
- Reset mid-phase immediately returns the block to RED_B with a full ALLRED_S count, regardless of state.

## Test plan
- **Reset and first cycle.** TICK_DIV=4, GREEN_S=5, YELLOW_S=2, ALLRED_S=1, enable=1. Release reset.
  - Required: phase=5 with count 01 for 4 cycles; then NS_G with 05 for 20 cycles; then NS_Y 02, RED_A 01, EW_G 05, EW_Y 02, RED_B 01.
  - One full cycle is 64 cycles.
- **BCD borrow.** GREEN_S=12.
  - Required: the NS_G display steps 12, 11, 10, 09, …, 01, with tens=1→0 on the 10→09 step.
- **Enable freeze.** Drop enable for 7 cycles mid-NS_G.
  - Required: all outputs are constant during the freeze; the phase ends exactly 7 cycles later than nominal.
- **Night entry and exit.**
  - Assert night_mode during EW_G. Required: the sequence continues EW_Y → RED_B, then FLASH at the RED_B expiry, with blank=1, ns=ew=010, and yellow toggling each 4 cycles.
  - Deassert night_mode. Required: at the next tick, RED_B with 01 and blank=0, then NS_G.
- **Short night pulse.** night_mode high for 2 cycles inside NS_G only.
  - Required: no FLASH; the normal cycle continues.
- **Async reset mid-phase.** Pulse rst_n low between clock edges during EW_Y.
  - Required: outputs go to the reset values immediately, without waiting for a clock edge.
- **Safety check in every test.** A concurrent check asserts the "never both heads non-red with a green" invariant.
